// File: rtl/sseg_number_writer.sv
// Converts a signed value to BCD (shift-add-3) and writes one digit per cycle
// into a seven-segment display array, handling sign, blanking, dp and overflow.
module sseg_number_writer #(
  parameter int SSEG_BITS = 2,
  parameter int SSEG_N    = 4,
  parameter int VAL_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [VAL_BITS-1:0]  value,
  input  logic                 dp_en,
  input  logic [SSEG_BITS-1:0] dp_pos,
  output logic                 wr,
  output logic [SSEG_BITS-1:0] sel,
  output logic                 en,
  output logic                 sign,
  output logic                 dp,
  output logic [3:0]           val,
  output logic                 busy,
  output logic                 done_tick
);

  localparam int ND = SSEG_N + 1;
  localparam int BW = 4 * ND;
  localparam int CW = $clog2(VAL_BITS + 1);

  typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_t;

  state_t               state, state_nx;
  logic [BW-1:0]        bcd, bcd_adj;
  logic [VAL_BITS-1:0]  mag;
  logic                 neg, dpe;
  logic [SSEG_BITS-1:0] dpp, dig;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 ovf, en_nx, sign_nx, dp_nx;
  logic [3:0]           val_nx;

  // busy stays high through the done_tick cycle, so block restarts there too
  assign accept = (state == IDLE) && start && !busy;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CONV;
      CONV:    if (cnt == '0) state_nx = WRITE;
      WRITE:   if (dig == SSEG_BITS'(SSEG_N - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < ND; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    int ms;
    int avail;
    ovf     = 1'b0;
    ms      = 0;
    avail   = neg ? SSEG_N - 1 : SSEG_N;
    en_nx   = 1'b0;
    sign_nx = 1'b0;
    dp_nx   = 1'b0;
    val_nx  = 4'd0;
    for (int i = 0; i < ND; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        ms = i;
        if (i >= avail) ovf = 1'b1;
      end
    end
    if (ovf) begin
      en_nx   = 1'b1;
      sign_nx = 1'b1;
    end else begin
      if (int'(dig) <= ms) begin
        en_nx  = 1'b1;
        val_nx = bcd[4*int'(dig) +: 4];
      end else if (dpe && (dig < dpp)) begin
        en_nx = 1'b1;
      end
      if (neg && (dig == SSEG_BITS'(SSEG_N - 1))) begin
        en_nx   = 1'b1;
        sign_nx = 1'b1;
        val_nx  = 4'd0;
      end
      if (dpe && (dig == dpp)) begin
        dp_nx = 1'b1;
        en_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bcd       <= '0;
      mag       <= '0;
      neg       <= 1'b0;
      dpe       <= 1'b0;
      dpp       <= '0;
      dig       <= '0;
      cnt       <= '0;
      wr        <= 1'b0;
      sel       <= '0;
      en        <= 1'b0;
      sign      <= 1'b0;
      dp        <= 1'b0;
      val       <= 4'd0;
      busy      <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != IDLE) || (state == DONE);
      done_tick <= (state == DONE);
      wr        <= (state == WRITE);
      sel       <= (state == WRITE) ? dig : '0;
      en        <= (state == WRITE) && en_nx;
      sign      <= (state == WRITE) && sign_nx;
      dp        <= (state == WRITE) && dp_nx;
      val       <= (state == WRITE) ? val_nx : 4'd0;
      case (state)
        IDLE: begin
          if (accept) begin
            neg <= value[VAL_BITS-1];
            mag <= value[VAL_BITS-1] ? (~value + 1'b1) : value;
            dpe <= dp_en;
            dpp <= dp_pos;
            bcd <= '0;
            dig <= '0;
            cnt <= CW'(VAL_BITS - 1);
          end
        end
        CONV: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          cnt        <= cnt - 1'b1;
        end
        WRITE:   dig <= dig + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_number_writer.sv
// Bench for sseg_number_writer: fixed vector table, randomized values against a
// decimal-arithmetic reference model, restart-while-busy and mid-write reset.
module tb_sseg_number_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] value = '0;
  logic        dp_en = 1'b0;
  logic [1:0]  dp_pos = '0;
  logic        wr, en, sign, dp, busy, done_tick;
  logic [1:0]  sel;
  logic [3:0]  val;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sseg_number_writer #(.SSEG_BITS(2), .SSEG_N(4), .VAL_BITS(12)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .dp_en(dp_en),
    .dp_pos(dp_pos), .wr(wr), .sel(sel), .en(en), .sign(sign), .dp(dp),
    .val(val), .busy(busy), .done_tick(done_tick)
  );

  typedef struct {
    int          v;
    bit          dpe;
    int          dpp;
    logic [27:0] expv;
  } vec_t;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [6:0] mk(bit e, bit s, bit p, int v);
    logic [3:0] v4;
    v4 = v[3:0];
    return {e, s, p, v4};
  endfunction

  function automatic int p10(int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // reference: decimal digits by division, display rules applied per digit
  function automatic logic [27:0] model(int v, bit dpe, int dpp);
    logic [27:0] r;
    bit neg, ovf, e, s, p;
    int m, avail, ms, dv;
    neg   = (v < 0);
    m     = neg ? -v : v;
    avail = neg ? 3 : 4;
    ovf   = (m >= p10(avail));
    ms    = 0;
    for (int i = 0; i < 5; i++) if ((m / p10(i)) % 10 != 0) ms = i;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      e = 0; s = 0; p = 0; dv = 0;
      if (ovf) begin
        e = 1; s = 1;
      end else begin
        if (d <= ms) begin
          e = 1; dv = (m / p10(d)) % 10;
        end else if (dpe && d < dpp) e = 1;
        if (neg && d == 3) begin
          e = 1; s = 1; dv = 0;
        end
        if (dpe && d == dpp) begin
          p = 1; e = 1;
        end
      end
      r[7*d +: 7] = mk(e, s, p, dv);
    end
    return r;
  endfunction

  task automatic do_txn(input int v, input bit dpe, input int dpp,
                        input logic [27:0] expv, input string name, input bit spam);
    int  nw, first_wr, done_c;
    bit  got_done, busy_ok;
    int  wrec[4];
    @(negedge clk);
    start  = 1'b1;
    value  = v[11:0];
    dp_en  = dpe;
    dp_pos = dpp[1:0];
    @(negedge clk);
    start    = 1'b0;
    nw       = 0;
    first_wr = -1;
    done_c   = -1;
    got_done = 0;
    busy_ok  = 1;
    for (int c = 0; c < 40 && !got_done; c++) begin
      if (c > 0) @(negedge clk);
      if (spam && c < 15) begin
        start  = 1'($urandom_range(0, 1));
        value  = 12'($urandom);
        dp_en  = 1'($urandom);
        dp_pos = 2'($urandom);
      end else start = 1'b0;
      if (wr) begin
        if (nw < 4) wrec[nw] = int'({sel, en, sign, dp, val});
        if (nw == 0) first_wr = c;
        nw++;
      end
      if (!busy) busy_ok = 0;
      if (done_tick) begin
        got_done = 1;
        done_c   = c;
      end
    end
    start = 1'b0;
    check({name, " done_seen"}, int'(got_done), 1);
    check({name, " write_count"}, nw, 4);
    check({name, " first_wr_cycle"}, first_wr, 13);
    check({name, " done_cycle"}, done_c, 17);
    check({name, " busy_held"}, int'(busy_ok), 1);
    for (int i = 0; i < 4 && i < nw; i++) begin
      logic [1:0] si;
      si = i[1:0];
      check($sformatf("%s write%0d", name, i), wrec[i], int'({si, expv[7*i +: 7]}));
    end
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{123,   0, 0, {mk(0,0,0,0), mk(1,0,0,1), mk(1,0,0,2), mk(1,0,0,3)}};
    tbl[1]  = '{-45,   0, 0, {mk(1,1,0,0), mk(0,0,0,0), mk(1,0,0,4), mk(1,0,0,5)}};
    tbl[2]  = '{0,     0, 0, {mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0), mk(1,0,0,0)}};
    tbl[3]  = '{7,     1, 2, {mk(0,0,0,0), mk(1,0,1,0), mk(1,0,0,0), mk(1,0,0,7)}};
    tbl[4]  = '{-2048, 0, 0, {mk(1,1,0,0), mk(1,1,0,0), mk(1,1,0,0), mk(1,1,0,0)}};
    tbl[5]  = '{2047,  0, 0, {mk(1,0,0,2), mk(1,0,0,0), mk(1,0,0,4), mk(1,0,0,7)}};
    tbl[6]  = '{-999,  0, 0, {mk(1,1,0,0), mk(1,0,0,9), mk(1,0,0,9), mk(1,0,0,9)}};
    tbl[7]  = '{-1000, 1, 0, {mk(1,1,0,0), mk(1,1,0,0), mk(1,1,0,0), mk(1,1,0,0)}};
    tbl[8]  = '{5,     1, 0, {mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0), mk(1,0,1,5)}};
    tbl[9]  = '{-3,    1, 3, {mk(1,1,1,0), mk(1,0,0,0), mk(1,0,0,0), mk(1,0,0,3)}};
    tbl[10] = '{1000,  0, 0, {mk(1,0,0,1), mk(1,0,0,0), mk(1,0,0,0), mk(1,0,0,0)}};
    tbl[11] = '{-2048, 1, 1, {mk(1,1,0,0), mk(1,1,0,0), mk(1,1,0,0), mk(1,1,0,0)}};

    #1;
    check("reset_outputs", int'({wr, sel, en, sign, dp, val, busy, done_tick}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      do_txn(tbl[i].v, tbl[i].dpe, tbl[i].dpp, tbl[i].expv, $sformatf("vec%0d", i), 0);

    // restart attempts while busy must be ignored
    do_txn(123, 0, 0, tbl[0].expv, "spam123", 1);
    do_txn(-45, 0, 0, tbl[1].expv, "spam_neg45", 1);

    for (int i = 0; i < 20; i++) begin
      int v, dpp;
      bit dpe, sp;
      v   = int'($urandom_range(0, 4095)) - 2048;
      dpe = 1'($urandom);
      dpp = int'($urandom_range(0, 3));
      sp  = 1'($urandom);
      do_txn(v, dpe, dpp, model(v, dpe, dpp), $sformatf("rnd%0d_v%0d", i, v), sp);
    end

    // reset in the middle of the write burst
    begin
      int nw, late;
      @(negedge clk);
      start = 1'b1;
      value = 12'd123;
      dp_en = 1'b0;
      @(negedge clk);
      start = 1'b0;
      nw = 0;
      for (int c = 0; c < 40 && nw < 2; c++) begin
        if (c > 0) @(negedge clk);
        if (wr) nw++;
      end
      check("rst_two_writes_seen", nw, 2);
      reset = 1'b1;
      #1;
      check("rst_async_clear", int'({wr, busy, done_tick}), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      late = 0;
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        if (wr || busy || done_tick) late++;
      end
      check("rst_no_resume", late, 0);
      do_txn(123, 0, 0, tbl[0].expv, "after_reset", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
